// File: rtl/dsi_lp_lane_rx.sv
// dsi_lp_lane_rx: low-power receiver for DSI lane zero.
// The LP_p/LP_n pads are synchronized and deglitched into an accepted line
// state. A sequencer then decodes escape entry, the entry command, LPDT bytes
// and the HS-request sequence. It flags illegal sequences, partial bytes and
// line states that are held too long.
module dsi_lp_lane_rx #(
   parameter int unsigned FILTER_CYCLES  = 2,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [7:0]  LPDT_CMD       = 8'hE1
) (
   input  logic       clk_sys,
   input  logic       rst,
   input  logic       lines_enable,
   input  logic       LP_p_input,
   input  logic       LP_n_input,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic [7:0] cmd_out,
   output logic       cmd_valid,
   output logic       lpdt_active,
   output logic       hs_rqst,
   output logic       stop_state,
   output logic       esc_error
);

   localparam logic [1:0] LP00   = 2'b00;
   localparam logic [1:0] LP01   = 2'b01;
   localparam logic [1:0] LP10   = 2'b10;
   localparam logic [1:0] LP11   = 2'b11;
   localparam logic [3:0] FILT_N = 4'(FILTER_CYCLES);
   localparam logic [7:0] TMO_N  = 8'(TIMEOUT_CYCLES);

   typedef enum logic [3:0] {
      ST_STOP      = 4'd0,
      ST_ESC_10    = 4'd1,
      ST_ESC_00    = 4'd2,
      ST_ESC_01    = 4'd3,
      ST_HS_01     = 4'd4,
      ST_HS_WAIT   = 4'd5,
      ST_CMD_RX    = 4'd6,
      ST_LPDT_RX   = 4'd7,
      ST_CMD_WAIT  = 4'd8,
      ST_ERROR     = 4'd9,
      ST_STOP_WAIT = 4'd10
   } state_t;

   logic       p_meta_q, p_sync_q, n_meta_q, n_sync_q;
   logic [1:0] smp_s;
   logic [1:0] cand_q;
   logic [3:0] cnt_q, cnt_d;
   logic [1:0] ls_q, ls_d, lsd_q;
   logic [7:0] tmo_q;
   logic [6:0] shreg_q;
   logic [2:0] bitcnt_q;
   state_t     state_q;
   logic       chg_s, bit_s, timed_s, expire_s;
   logic [7:0] byte_s;
   logic [7:0] data_out_q, cmd_out_q;
   logic       data_valid_q, cmd_valid_q, lpdt_active_q, hs_rqst_q;
   logic       stop_state_q, esc_error_q;

   // Two-flop synchronizers on the asynchronous pad inputs
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         p_meta_q <= 1'b1;
         p_sync_q <= 1'b1;
         n_meta_q <= 1'b1;
         n_sync_q <= 1'b1;
      end else begin
         p_meta_q <= LP_p_input;
         p_sync_q <= p_meta_q;
         n_meta_q <= LP_n_input;
         n_sync_q <= n_meta_q;
      end
   end

   assign smp_s = {p_sync_q, n_sync_q};

   // Glitch filter: accept a new line state after FILTER_CYCLES equal samples
   always_comb begin
      cnt_d = 4'd1;
      ls_d  = ls_q;
      if (smp_s == cand_q) begin
         if (cnt_q == 4'hF) begin
            cnt_d = cnt_q;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end else begin
         cnt_d = 4'd1;
      end
      if ((cnt_d >= FILT_N) && (smp_s != ls_q)) begin
         ls_d = smp_s;
      end else begin
         ls_d = ls_q;
      end
   end

   // Filter state registers; the line idles at LP-11
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         cand_q <= LP11;
         cnt_q  <= 4'hF;
         ls_q   <= LP11;
      end else begin
         cand_q <= smp_s;
         cnt_q  <= cnt_d;
         ls_q   <= ls_d;
      end
   end

   // lsd_q is the previous accepted state, so each change is seen as prev -> cur
   assign chg_s    = (ls_q != lsd_q);
   assign bit_s    = (lsd_q == LP10);
   assign byte_s   = {shreg_q, bit_s};
   assign timed_s  = (state_q != ST_HS_WAIT) && (state_q != ST_CMD_WAIT) &&
                     (state_q != ST_ERROR) && (state_q != ST_STOP_WAIT);
   assign expire_s = timed_s && !chg_s && (ls_q != LP11) && (tmo_q == TMO_N);

   // Line-state sequencer with registered outputs and single-cycle pulses
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state_q       <= ST_STOP;
         lsd_q         <= LP11;
         tmo_q         <= 8'd0;
         bitcnt_q      <= 3'd0;
         shreg_q       <= 7'd0;
         data_out_q    <= 8'd0;
         cmd_out_q     <= 8'd0;
         data_valid_q  <= 1'b0;
         cmd_valid_q   <= 1'b0;
         hs_rqst_q     <= 1'b0;
         esc_error_q   <= 1'b0;
         lpdt_active_q <= 1'b0;
         stop_state_q  <= 1'b1;
      end else begin
         lsd_q         <= ls_q;
         data_valid_q  <= 1'b0;
         cmd_valid_q   <= 1'b0;
         hs_rqst_q     <= 1'b0;
         esc_error_q   <= 1'b0;
         lpdt_active_q <= (state_q == ST_LPDT_RX) && lines_enable;
         stop_state_q  <= (state_q == ST_STOP) && (ls_q == LP11);
         if (chg_s) begin
            tmo_q <= 8'd0;
         end else if (tmo_q != TMO_N) begin
            tmo_q <= tmo_q + 8'd1;
         end else begin
            tmo_q <= tmo_q;
         end

         if (!lines_enable) begin
            state_q  <= ST_STOP_WAIT;
            bitcnt_q <= 3'd0;
         end else if (expire_s) begin
            state_q     <= ST_ERROR;
            esc_error_q <= 1'b1;
         end else begin
            case (state_q)
               ST_STOP: begin
                  if (!chg_s) begin
                     state_q <= ST_STOP;
                  end else if (ls_q == LP10) begin
                     state_q <= ST_ESC_10;
                  end else if (ls_q == LP01) begin
                     state_q <= ST_HS_01;
                  end else if (ls_q == LP00) begin
                     state_q     <= ST_ERROR;
                     esc_error_q <= 1'b1;
                  end else begin
                     state_q <= ST_STOP;
                  end
               end
               ST_ESC_10, ST_ESC_00, ST_ESC_01, ST_HS_01: begin
                  if (!chg_s) begin
                     state_q <= state_q;
                  end else if ((state_q == ST_ESC_10) && (ls_q == LP00)) begin
                     state_q <= ST_ESC_00;
                  end else if ((state_q == ST_ESC_00) && (ls_q == LP01)) begin
                     state_q <= ST_ESC_01;
                  end else if ((state_q == ST_ESC_01) && (ls_q == LP00)) begin
                     state_q  <= ST_CMD_RX;
                     bitcnt_q <= 3'd0;
                  end else if ((state_q == ST_HS_01) && (ls_q == LP00)) begin
                     state_q   <= ST_HS_WAIT;
                     hs_rqst_q <= 1'b1;
                  end else begin
                     state_q     <= ST_ERROR;
                     esc_error_q <= 1'b1;
                  end
               end
               ST_HS_WAIT, ST_CMD_WAIT, ST_ERROR, ST_STOP_WAIT: begin
                  if (ls_q == LP11) begin
                     state_q <= ST_STOP;
                  end else begin
                     state_q <= state_q;
                  end
               end
               ST_CMD_RX, ST_LPDT_RX: begin
                  if (!chg_s) begin
                     state_q <= state_q;
                  end else if (ls_q == LP00) begin
                     if (lsd_q == LP11) begin
                        state_q     <= ST_ERROR;
                        esc_error_q <= 1'b1;
                     end else begin
                        // Pulse returned to LP-00: commit one bit, MSB first
                        shreg_q  <= byte_s[6:0];
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q != 3'd7) begin
                           state_q <= state_q;
                        end else if (state_q == ST_CMD_RX) begin
                           cmd_out_q   <= byte_s;
                           cmd_valid_q <= 1'b1;
                           state_q     <= (byte_s == LPDT_CMD) ? ST_LPDT_RX : ST_CMD_WAIT;
                        end else begin
                           data_out_q   <= byte_s;
                           data_valid_q <= 1'b1;
                           state_q      <= ST_LPDT_RX;
                        end
                     end
                  end else if (ls_q == LP11) begin
                     if (lsd_q == LP10) begin
                        // Mark-1 exit; a partially received byte is dropped
                        state_q     <= ST_STOP;
                        bitcnt_q    <= 3'd0;
                        esc_error_q <= (bitcnt_q != 3'd0);
                     end else begin
                        state_q     <= ST_ERROR;
                        esc_error_q <= 1'b1;
                     end
                  end else if (lsd_q != LP00) begin
                     state_q     <= ST_ERROR;
                     esc_error_q <= 1'b1;
                  end else begin
                     state_q <= state_q;
                  end
               end
               default: begin
                  state_q     <= ST_ERROR;
                  esc_error_q <= 1'b1;
               end
            endcase
         end
      end
   end

   assign data_out    = data_out_q;
   assign data_valid  = data_valid_q;
   assign cmd_out     = cmd_out_q;
   assign cmd_valid   = cmd_valid_q;
   assign lpdt_active = lpdt_active_q;
   assign hs_rqst     = hs_rqst_q;
   assign stop_state  = stop_state_q;
   assign esc_error   = esc_error_q;

endmodule

// File: doc/dsi_lp_lane_rx.md
# dsi_lp_lane_rx

Low-power lane receiver for the DSI link: the receive-side counterpart of the LP escape-mode transmitter in our lane logic. It samples the asynchronous LP_p/LP_n pad inputs, filters glitches, and tracks the LP line-state sequence. It decodes escape-mode entry, the 8-bit entry command and spaced-one-hot Low-Power Data Transmission (LPDT) bytes, and reports HS-request entry. It sits between the LP input buffers and the packet-level receive logic on lane zero.

## Interface
- FILTER_CYCLES, 2: consecutive identical synchronized samples required before a line-state change is accepted (1..15).
- TIMEOUT_CYCLES, 255: maximum cycles an accepted non-LP-11 line state may persist before it is treated as an error (8-bit counter).
- LPDT_CMD, 8'hE1: entry command value that selects LPDT.
- clk_sys  in  1  system clock; all logic in this domain.
- rst  in  1  reset, asynchronous, active-high.
- lines_enable  in  1  0 forces state STOP_WAIT and suppresses all output pulses.
- LP_p_input  in  1  Dp LP receiver output, asynchronous.
- LP_n_input  in  1  Dn LP receiver output, asynchronous.
- data_out  out  8  last received LPDT byte.
- data_valid  out  1  1-cycle pulse; data_out is valid in that cycle.
- cmd_out  out  8  last received entry command.
- cmd_valid  out  1  1-cycle pulse on entry-command completion.
- lpdt_active  out  1  high while in LPDT_RX.
- hs_rqst  out  1  1-cycle pulse when the HS-request sequence is detected.
- stop_state  out  1  accepted line state is LP-11 and the FSM is in STOP.
- esc_error  out  1  1-cycle pulse on an illegal sequence, a partial byte, or a timeout.

## Operation
- Front end: 2-flop synchronizer per line. Filtered state ls[1:0] = {Dp,Dn} updates only after FILTER_CYCLES equal consecutive samples. ls resets to 2'b11.
- Bit encoding: MSB first. Pulse LP-10 = 1, LP-01 = 0. Each pulse is bracketed by LP-00. A bit commits when ls returns from the pulse to LP-00.
- FSM states and transitions on ls changes:
  - STOP: 10 -> ESC_10; 01 -> HS_01; 00 -> ERROR.
  - ESC_10: 00 -> ESC_00; otherwise -> ERROR.
  - ESC_00: 01 -> ESC_01; otherwise -> ERROR.
  - ESC_01: 00 -> CMD_RX, with bit counter 0; otherwise -> ERROR.
  - HS_01: 00 -> pulse hs_rqst, go to HS_WAIT; otherwise -> ERROR.
  - HS_WAIT: ignores all line activity and timeout; 11 -> STOP. No error from this state.
  - CMD_RX: receives 8 bits.
    - On the 8th commit: cmd_out, cmd_valid.
    - If the value equals LPDT_CMD -> LPDT_RX; else -> CMD_WAIT.
  - LPDT_RX: receives bytes back to back; each 8th commit produces data_out/data_valid, the counter wraps to 0, and reception continues.
  - CMD_WAIT: 11 -> STOP; other changes are ignored.
  - ERROR: 11 -> STOP.
- Mark/exit: in CMD_RX or LPDT_RX, a pulse of LP-10 followed directly by LP-11 is Mark-1 -> STOP, with no commit.
  - If the bit counter is nonzero at exit, the partial byte is discarded and esc_error pulses.
- Illegal transitions in CMD_RX/LPDT_RX -> ERROR with an esc_error pulse:
  - LP-11 direct from LP-00.
  - LP-01 followed by LP-11.
  - LP-10 <-> LP-01 without an intervening LP-00.
- Timeout: the counter reloads on every ls change. It expires after TIMEOUT_CYCLES while ls != 11 in any state except HS_WAIT, CMD_WAIT and ERROR. Expiry -> ERROR with an esc_error pulse.
- esc_error pulses once per entry into ERROR.
- lines_enable = 0: FSM goes to STOP_WAIT (behaves as ERROR but with no esc_error pulse) and the bit counter clears.

## Timing
- Reset values: data_out 0, cmd_out 0, data_valid 0, cmd_valid 0, hs_rqst 0, esc_error 0, lpdt_active 0, stop_state 1, FSM STOP, ls 11.
- Pad-to-ls latency: 2 + FILTER_CYCLES cycles after the input settles.
- data_valid, cmd_valid and hs_rqst assert in the cycle after the cycle in which ls first shows the committing LP-00. data_out/cmd_out hold until the next update.
- Pulses are registered and last exactly 1 cycle. data_valid and cmd_valid are never high together.
- Minimum supported half-bit width: FILTER_CYCLES + 2 cycles.
- Reset mid-byte: everything returns to reset values immediately, and no output pulse is produced.

## Test plan
- Escape entry, 0xE1 command, then bytes 0xA5, 0x3C with half-bit 15 cycles, then Mark-1 -> cmd_valid with cmd_out=E1; data_valid twice with A5 then 3C; stop_state back to 1; no esc_error.
- Entry with command 0x1E (non-LPDT) followed by arbitrary pulses -> cmd_out=1E, lpdt_active stays 0, no data_valid, and return to STOP on LP-11.
- LP-11 -> LP-01 -> LP-00 -> LP-11 -> a single hs_rqst pulse, stop_state=1 afterwards.
- Mark-1 after 3 bits of a byte -> esc_error pulse, no data_valid, FSM in STOP.
- 1-cycle LP-00 glitch on an LP-11 line with FILTER_CYCLES=2 -> ls unchanged, no error. Line held at LP-00 for 300 cycles in LPDT_RX -> esc_error after 255 cycles.
- rst asserted between bits 4 and 5 of 0xA5 -> all outputs at reset values. Subsequent full sequence with byte 0x5A -> data_out=5A.
